// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: divides mck into scki/bck/lrck, shifts stereo samples
// out on sdout and in from sdin, and exchanges sample pairs over valid/ready.
module i2s_frame_ctrl #(
    parameter int BCK_DIV       = 16,
    parameter int BITS_PER_SLOT = 32,
    parameter int DATA_W        = 24,
    parameter int DELAY         = 1
) (
    input  logic              mck,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sdin,
    output logic              scki,
    output logic              bck,
    output logic              lrck,
    output logic              sdout,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              overrun,
    output logic              underrun
);

    localparam int HALF  = BCK_DIV / 2;
    localparam int FRAME = 2 * BITS_PER_SLOT;
    localparam int DIV_W = $clog2(BCK_DIV);
    localparam int BIT_W = $clog2(FRAME);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               scki_q, bck_q, lrck_q, sdout_q;
    logic               bck_d, lrck_d;
    logic [DATA_W-1:0]  hold_l_q, hold_r_q;
    logic [DATA_W-1:0]  txsh_l_q, txsh_r_q;
    logic [DATA_W-1:0]  rxsh_l_q, rxsh_r_q;
    logic [DATA_W-1:0]  rx_left_q, rx_right_q;
    logic               rx_valid_q, tx_ready_q, overrun_q, underrun_q;
    logic               cap_q;

    logic               run, div_wrap, bit_last, frame_start, right;
    logic               data_bit, last_rx, sample_now;
    logic [BIT_W-1:0]   slot;
    int                 slot_i;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  tx_word;

    always_comb begin
        run         = (state_q != IDLE);
        div_wrap    = (div_q == DIV_W'(BCK_DIV - 1));
        bit_last    = (bit_q == BIT_W'(FRAME - 1));
        frame_start = run && (div_q == '0) && (bit_q == '0);
        right       = (bit_q >= BIT_W'(BITS_PER_SLOT));
        slot        = right ? (bit_q - BIT_W'(BITS_PER_SLOT)) : bit_q;
        slot_i      = int'(slot);
        data_bit    = (slot_i >= DELAY) && (slot_i < DELAY + DATA_W);
        last_rx     = right && (slot_i == DELAY + DATA_W - 1);
        idx         = IDX_W'(DATA_W - 1 - (slot_i - DELAY));
        sample_now  = run && (div_q == DIV_W'(HALF)) && data_bit;

        // At frame start the shift regs are loading this very cycle, so read the source.
        if (frame_start)
            tx_word = tx_ready_q ? '0 : hold_l_q;
        else
            tx_word = right ? txsh_r_q : txsh_l_q;

        state_d = state_q;
        div_d   = '0;
        bit_d   = '0;
        if (run) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap)
                bit_d = bit_last ? '0 : bit_q + 1'b1;
            else
                bit_d = bit_q;
        end

        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (div_wrap && bit_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        bck_d  = (state_d != IDLE) && (div_d >= DIV_W'(HALF));
        lrck_d = (state_d != IDLE) && (bit_d >= BIT_W'(BITS_PER_SLOT));
    end

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            scki_q     <= 1'b0;
            bck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            sdout_q    <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            txsh_l_q   <= '0;
            txsh_r_q   <= '0;
            rxsh_l_q   <= '0;
            rxsh_r_q   <= '0;
            rx_left_q  <= '0;
            rx_right_q <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            scki_q  <= ~scki_q;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            bck_q   <= bck_d;
            lrck_q  <= lrck_d;

            if (state_d == IDLE)
                sdout_q <= 1'b0;
            else if (run && (div_q == '0))
                sdout_q <= data_bit ? tx_word[idx] : 1'b0;

            // Frame start consumes the holding state as it was before any same-cycle handshake.
            if (frame_start) begin
                txsh_l_q <= tx_ready_q ? '0 : hold_l_q;
                txsh_r_q <= tx_ready_q ? '0 : hold_r_q;
            end
            underrun_q <= frame_start && tx_ready_q;

            if (tx_valid && tx_ready_q) begin
                hold_l_q   <= tx_left;
                hold_r_q   <= tx_right;
                tx_ready_q <= 1'b0;
            end else if (frame_start) begin
                tx_ready_q <= 1'b1;
            end

            if (sample_now) begin
                if (right)
                    rxsh_r_q <= {rxsh_r_q[DATA_W-2:0], sdin};
                else
                    rxsh_l_q <= {rxsh_l_q[DATA_W-2:0], sdin};
            end
            cap_q <= sample_now && last_rx;

            if (cap_q) begin
                rx_left_q  <= rxsh_l_q;
                rx_right_q <= rxsh_r_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            overrun_q <= cap_q && rx_valid_q && !rx_ready;
        end
    end

    assign scki     = scki_q;
    assign bck      = bck_q;
    assign lrck     = lrck_q;
    assign sdout    = sdout_q;
    assign rx_left  = rx_left_q;
    assign rx_right = rx_right_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl: clock ratios, loopback data, underrun,
// overrun, drain to idle and mid-frame reset.
module tb_i2s_frame_ctrl;

    localparam int DW = 24;

    logic          mck = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          loopback = 1'b0;
    logic          sdin;
    logic          scki, bck, lrck, sdout;
    logic [DW-1:0] rx_left, rx_right;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] tx_left = '0, tx_right = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, overrun, underrun;

    assign sdin = loopback & sdout;

    i2s_frame_ctrl dut (
        .mck(mck), .reset_n(reset_n), .enable(enable), .sdin(sdin),
        .scki(scki), .bck(bck), .lrck(lrck), .sdout(sdout),
        .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overrun(overrun), .underrun(underrun)
    );

    always #5 mck = ~mck;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int   bck_r1, bck_r2, lr_r1, lr_r2, lr_edges, lr_bad, ur_cnt, ur_idx;
    int   sd_hi, rdy_lo, scki_bad, ov_cnt, rises, falls;
    logic pb, pl, ps, got;

    initial begin
        // reset state
        repeat (3) @(negedge mck);
        check("rst_scki", scki, 0);
        check("rst_bck", bck, 0);
        check("rst_lrck", lrck, 0);
        check("rst_sdout", sdout, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_overrun", overrun, 0);
        check("rst_underrun", underrun, 0);
        check("rst_rx_left", rx_left, 0);

        // clock ratios, lrck alignment, underrun with no tx data
        reset_n = 1'b1;
        enable  = 1'b1;
        bck_r1 = -1; bck_r2 = -1; lr_r1 = -1; lr_r2 = -1;
        lr_edges = 0; lr_bad = 0; ur_cnt = 0; sd_hi = 0; rdy_lo = 0; scki_bad = 0;
        pb = bck; pl = lrck; ps = scki;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge mck);
            if (scki === ps) scki_bad++;
            if (bck && !pb) begin
                if (bck_r1 < 0) bck_r1 = i;
                else if (bck_r2 < 0) bck_r2 = i;
            end
            if (lrck !== pl) begin
                lr_edges++;
                if (!(pb && !bck)) lr_bad++;
                if (lrck) begin
                    if (lr_r1 < 0) lr_r1 = i;
                    else if (lr_r2 < 0) lr_r2 = i;
                end
            end
            if (underrun) ur_cnt++;
            if (sdout) sd_hi++;
            if (!tx_ready) rdy_lo++;
            pb = bck; pl = lrck; ps = scki;
        end
        check("scki_toggle_misses", scki_bad, 0);
        check("bck_first_rise", bck_r1, 9);
        check("bck_period", bck_r2 - bck_r1, 16);
        check("lrck_period", lr_r2 - lr_r1, 1024);
        check("lrck_first_rise", lr_r1, 513);
        check("lrck_edges", lr_edges, 4);
        check("lrck_not_on_bck_fall", lr_bad, 0);
        check("underrun_pulses", ur_cnt, 3);
        check("idle_sdout_high", sd_hi, 0);
        check("idle_tx_ready_low", rdy_lo, 0);

        // loopback of one pair
        reset_n = 1'b0;
        @(negedge mck);
        loopback = 1'b1;
        tx_left  = 24'hA5A5A5;
        tx_right = 24'h5A5A5A;
        tx_valid = 1'b1;
        reset_n  = 1'b1;
        @(negedge mck);
        check("tx_accept_ready", tx_ready, 0);
        tx_valid = 1'b0;
        got = 1'b0; ur_cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mck);
            if (underrun) ur_cnt++;
            if (rx_valid) begin got = 1'b1; break; end
        end
        check("rx_valid_wait", got, 1);
        check("loop_rx_left", rx_left, 24'hA5A5A5);
        check("loop_rx_right", rx_right, 24'h5A5A5A);
        check("loop_underrun", ur_cnt, 0);
        check("loop_tx_ready", tx_ready, 1);

        // second pair while the first is still unread -> overrun
        tx_left  = 24'h123456;
        tx_right = 24'hABCDEF;
        tx_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge mck);
            if (!tx_ready) begin got = 1'b1; break; end
        end
        tx_valid = 1'b0;
        check("tx2_accept", got, 1);
        got = 1'b0; ov_cnt = 0; ur_cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mck);
            if (underrun) ur_cnt++;
            if (overrun) begin got = 1'b1; ov_cnt++; break; end
        end
        check("overrun_wait", got, 1);
        check("ovr_rx_left", rx_left, 24'h123456);
        check("ovr_rx_right", rx_right, 24'hABCDEF);
        check("ovr_rx_valid", rx_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge mck);
            if (overrun) ov_cnt++;
        end
        check("overrun_pulses", ov_cnt, 1);
        check("ovr_underrun", ur_cnt, 0);
        rx_ready = 1'b1;
        @(negedge mck);
        rx_ready = 1'b0;
        check("rx_handshake_clear", rx_valid, 0);

        // drop enable at bit 10 -> finish the frame, then idle
        got = 1'b0; pl = lrck;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mck);
            if (pl && !lrck) begin got = 1'b1; break; end
            pl = lrck;
        end
        check("frame_start_wait", got, 1);
        falls = 0; pb = bck;
        for (int i = 0; i < 400 && falls < 10; i++) begin
            @(negedge mck);
            if (pb && !bck) falls++;
            pb = bck;
        end
        check("bit10_wait", falls, 10);
        enable = 1'b0;
        rises = 0; pb = bck;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mck);
            if (bck && !pb) rises++;
            pb = bck;
        end
        check("drain_bck_rises", rises, 54);
        check("idle_bck", bck, 0);
        check("idle_lrck", lrck, 0);
        check("idle_sdout", sdout, 0);

        // reset mid right slot
        rx_ready = 1'b1;
        @(negedge mck);
        rx_ready = 1'b0;
        enable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mck);
            if (rx_valid) begin got = 1'b1; break; end
        end
        check("rx_valid_wait2", got, 1);
        check("pre_reset_lrck", lrck, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_bck", bck, 0);
        check("async_rst_lrck", lrck, 0);
        check("async_rst_sdout", sdout, 0);
        check("async_rst_rx_valid", rx_valid, 0);
        check("async_rst_tx_ready", tx_ready, 1);
        check("async_rst_scki", scki, 0);
        @(negedge mck);
        reset_n = 1'b1;
        bck_r1 = -1; lr_r1 = -1; ur_idx = -1;
        pb = bck; pl = lrck;
        for (int i = 1; i <= 600; i++) begin
            @(negedge mck);
            if (bck && !pb && bck_r1 < 0) bck_r1 = i;
            if (lrck && !pl && lr_r1 < 0) lr_r1 = i;
            if (underrun && ur_idx < 0) ur_idx = i;
            pb = bck; pl = lrck;
        end
        check("restart_bck_rise", bck_r1, 9);
        check("restart_lrck_rise", lr_r1, 513);
        check("restart_underrun_at", ur_idx, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
